dw_up_converter: RTL and testbench
==================================

Name: dw_up_converter

Overview:
- Width up-converter: packs a stream of narrow INPUT_DW beats into OUTPUT_DW words, least-significant lane first.
- Counterpart of the existing width down-converter. It sits on the write/return path where narrow AXI-side beats are widened back to the XDMA datapath width.
- Supports early termination (last_i) with zero fill and a lane mask.
- Two-stage buffered (assembly + output register) to sustain one narrow beat per cycle under a draining sink.

Parameters:
- INPUT_DW, 64, narrow input width in bits.
- OUTPUT_DW, 512, wide output width in bits.
- UP_RATIO, OUTPUT_DW/INPUT_DW, lanes per output word; dependent, do not override.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- data_i  input  INPUT_DW  narrow beat.
- valid_i  input  1  input beat valid.
- last_i  input  1  beat ends the current packet; flush the partial word.
- ready_o  output  1  input handshake ready.
- data_o  output  OUTPUT_DW  assembled wide word.
- lanes_o  output  UP_RATIO  bit k=1 if lane k holds real data.
- last_o  output  1  word was closed by last_i.
- valid_o  output  1  output word valid.
- ready_i  input  1  sink ready.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Static checks: OUTPUT_DW % INPUT_DW == 0 and UP_RATIO >= 2; otherwise $fatal at elaboration.
- State:
  - lane counter cnt_q, width $clog2(UP_RATIO);
  - assembly register asm_q, with lane mask asm_lanes_q and asm_last_q;
  - full_q: assembly holds a complete word awaiting output;
  - output register out_q, with valid_o/lanes_o/last_o.
- Reset (rst_i high at a clock edge):
  - cnt_q=0, asm_q=0, asm_lanes_q=0, full_q=0;
  - valid_o=0, data_o=0, lanes_o=0, last_o=0.
  - ready_o=0 while rst_i is high; ready_o=1 in the first cycle after reset.
  - A partial word in flight at reset is discarded silently.
- Handshakes:
  - in_fire = valid_i && ready_o; out_fire = valid_o && ready_i; out_free = !valid_o || ready_i.
  - ready_o = !full_q && !rst_i. There is no combinational path from ready_i.
  - valid_o, data_o, lanes_o and last_o hold stable while valid_o && !ready_i.
- Accepted beat (in_fire):
  - data_i is written into lane cnt_q, i.e. bits [cnt_q*INPUT_DW +: INPUT_DW], and asm_lanes_q[cnt_q] is set.
  - The beat is "completing" if cnt_q==UP_RATIO-1 or last_i==1. Otherwise cnt_q increments.
- Completing beat:
  - cnt_q returns to 0. Unfilled lanes of the word are forced to 0 and their lanes_o bits to 0.
  - last_o = last_i of the completing beat.
  - If out_free in the same cycle: the merged word loads the output register directly; valid_o=1 the next cycle (1-cycle latency). Assembly is cleared.
  - Otherwise: the word is held in asm_q and full_q=1 (ready_o drops the next cycle).
- full_q drain:
  - When full_q && out_free, asm_q moves to the output register and full_q clears. asm_q/asm_lanes_q clear.
  - ready_o is 1 again the following cycle.
- Output drain: on out_fire with no new load, valid_o=0 next cycle. Simultaneous out_fire and load: the new word replaces the old with valid_o staying 1.
- Throughput: with ready_i held 1, UP_RATIO accepted beats yield one word; ready_o never deasserts.
- Edge cases:
  - last_i on lane 0 gives lanes_o = 0...01.
  - last_i on lane UP_RATIO-1 gives a full word with last_o=1.
  - valid_i low between beats of a word only stalls cnt_q.
  - Beats arriving while full_q=1 are not accepted (ready_o=0).

Test Plan:
1. Ratio 8, ready_i=1; 8 beats with data_i=k+1 (k=0..7), last_i=0. One cycle after beat 7: valid_o=1, lane k of data_o=k+1, lanes_o=0xFF, last_o=0; ready_o stays 1 throughout.
2. 3 beats 0xA,0xB,0xC with last_i on the third. Lanes 0..2=A,B,C, lanes 3..7=0, lanes_o=0x07, last_o=1. The next beat lands in lane 0.
3. ready_i=0 with 16 beats offered. Word 1 sits in the output register and word 2 completes into assembly. ready_o=0 from the cycle after beat 16 and data_o is held stable. Raising ready_i: word 1 handshakes, word 2 appears the next cycle, then ready_o returns to 1.
4. rst_i=1 after 5 beats, then 8 fresh beats. No output from the aborted word; the first valid_o carries only the fresh data with lanes_o=0xFF. Outputs are 0 and ready_o=0 during reset.
5. Random valid_i/ready_i (50% each) over 1000 beats with random last_i, checked against a scoreboard packing model. Data and lane order are preserved, no loss or duplication, and outputs are stable under backpressure.
6. Single-beat packets back-to-back (last_i=1 on every beat), ready_i=1. One word per cycle, each with lanes_o=0x01 and last_o=1.

Source files
------------

// File: rtl/dw_up_converter_if.sv
// Stream bundle for the width up-converter: narrow beats in, wide lane-masked words out.
// The slave modport is the converter's view; master is the surrounding logic's view.
interface dw_up_converter_if #(
  parameter int unsigned INPUT_DW  = 64,
  parameter int unsigned OUTPUT_DW = 512
);
  localparam int unsigned UP_RATIO = OUTPUT_DW / INPUT_DW;

  logic [INPUT_DW-1:0]  data_i;
  logic                 valid_i;
  logic                 last_i;
  logic                 ready_o;
  logic [OUTPUT_DW-1:0] data_o;
  logic [UP_RATIO-1:0]  lanes_o;
  logic                 last_o;
  logic                 valid_o;
  logic                 ready_i;

  modport slave (
    input  data_i,
    input  valid_i,
    input  last_i,
    input  ready_i,
    output ready_o,
    output data_o,
    output lanes_o,
    output last_o,
    output valid_o
  );

  modport master (
    output data_i,
    output valid_i,
    output last_i,
    output ready_i,
    input  ready_o,
    input  data_o,
    input  lanes_o,
    input  last_o,
    input  valid_o
  );
endinterface

// File: rtl/dw_up_converter.sv
// Width up-converter: packs narrow beats into wide words, lane 0 first, with early
// termination (zero-filled, lane-masked) and an assembly + output register pair.
module dw_up_converter #(
  parameter int unsigned INPUT_DW  = 64,
  parameter int unsigned OUTPUT_DW = 512,
  localparam int unsigned UP_RATIO = OUTPUT_DW / INPUT_DW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dw_up_converter_if.slave   bus
);

  if ((OUTPUT_DW % INPUT_DW) != 0 || UP_RATIO < 2) begin : g_bad_params
    $fatal(1, "dw_up_converter: OUTPUT_DW must be a multiple (>=2x) of INPUT_DW");
  end

  localparam int unsigned CntW = (UP_RATIO > 1) ? $clog2(UP_RATIO) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(UP_RATIO - 1);

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [OUTPUT_DW-1:0] asm_q, asm_d;
  logic [UP_RATIO-1:0]  asm_lanes_q, asm_lanes_d;
  logic                 asm_last_q, asm_last_d;
  logic                 full_q, full_d;
  logic [OUTPUT_DW-1:0] out_data_q, out_data_d;
  logic [UP_RATIO-1:0]  out_lanes_q, out_lanes_d;
  logic                 out_last_q, out_last_d;
  logic                 out_valid_q, out_valid_d;

  logic                 ready;
  logic                 in_fire;
  logic                 out_free;
  logic                 completing;
  logic [OUTPUT_DW-1:0] merged_data;
  logic [UP_RATIO-1:0]  merged_lanes;

  // ready_o depends only on registered state and reset, never on ready_i.
  assign ready      = !full_q && !rst_i;
  assign in_fire    = bus.valid_i && ready;
  assign out_free   = !out_valid_q || bus.ready_i;
  assign completing = in_fire && ((cnt_q == LastLane) || bus.last_i);

  // Current assembly with the incoming beat dropped into lane cnt_q; unfilled lanes zeroed.
  always_comb begin
    merged_data  = asm_q;
    merged_lanes = asm_lanes_q;
    for (int k = 0; k < int'(UP_RATIO); k++) begin
      if (cnt_q == CntW'(k)) begin
        merged_data[k*INPUT_DW +: INPUT_DW] = bus.data_i;
        merged_lanes[k]                     = 1'b1;
      end
      if (!merged_lanes[k]) begin
        merged_data[k*INPUT_DW +: INPUT_DW] = '0;
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    asm_lanes_d = asm_lanes_q;
    asm_last_d  = asm_last_q;
    full_d      = full_q;
    out_data_d  = out_data_q;
    out_lanes_d = out_lanes_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && bus.ready_i) begin
      out_valid_d = 1'b0;
    end

    if (full_q) begin
      // No beat can be accepted here; only the parked word may move on.
      if (out_free) begin
        out_data_d  = asm_q;
        out_lanes_d = asm_lanes_q;
        out_last_d  = asm_last_q;
        out_valid_d = 1'b1;
        full_d      = 1'b0;
        asm_d       = '0;
        asm_lanes_d = '0;
        asm_last_d  = 1'b0;
      end
    end else if (completing) begin
      cnt_d = '0;
      if (out_free) begin
        out_data_d  = merged_data;
        out_lanes_d = merged_lanes;
        out_last_d  = bus.last_i;
        out_valid_d = 1'b1;
        asm_d       = '0;
        asm_lanes_d = '0;
        asm_last_d  = 1'b0;
      end else begin
        asm_d       = merged_data;
        asm_lanes_d = merged_lanes;
        asm_last_d  = bus.last_i;
        full_d      = 1'b1;
      end
    end else if (in_fire) begin
      asm_d       = merged_data;
      asm_lanes_d = merged_lanes;
      cnt_d       = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      asm_lanes_q <= '0;
      asm_last_q  <= 1'b0;
      full_q      <= 1'b0;
      out_data_q  <= '0;
      out_lanes_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      asm_lanes_q <= asm_lanes_d;
      asm_last_q  <= asm_last_d;
      full_q      <= full_d;
      out_data_q  <= out_data_d;
      out_lanes_q <= out_lanes_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.data_o  = out_data_q;
  assign bus.lanes_o = out_lanes_q;
  assign bus.last_o  = out_last_q;
  assign bus.valid_o = out_valid_q;

  // A presented word must not change until the sink takes it.
  property p_hold_under_backpressure;
    @(posedge clk_i) disable iff (rst_i)
      (out_valid_q && !bus.ready_i) |=>
        (out_valid_q && $stable(out_data_q) && $stable(out_lanes_q) && $stable(out_last_q));
  endproperty
  a_hold_under_backpressure : assert property (p_hold_under_backpressure);

  // Filled lanes always form a contiguous run starting at lane 0.
  property p_lanes_contiguous;
    @(posedge clk_i) disable iff (rst_i)
      out_valid_q |-> (out_lanes_q[0] && ((out_lanes_q & (out_lanes_q + UP_RATIO'(1))) == '0));
  endproperty
  a_lanes_contiguous : assert property (p_lanes_contiguous);

endmodule

// File: tb/tb_dw_up_converter.sv
// Bench for dw_up_converter: directed packing scenarios plus a randomized stream, with a
// packing model feeding an expected-word queue that an independent monitor drains.
module tb_dw_up_converter;
  localparam int unsigned InDw  = 64;
  localparam int unsigned OutDw = 512;
  localparam int unsigned Ratio = OutDw / InDw;

  typedef struct {
    logic [OutDw-1:0] data;
    logic [Ratio-1:0] lanes;
    logic             last;
  } word_t;

  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_words = 0;
  word_t exp_q[$];

  dw_up_converter_if #(.INPUT_DW(InDw), .OUTPUT_DW(OutDw)) bus ();

  dw_up_converter #(.INPUT_DW(InDw), .OUTPUT_DW(OutDw)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [OutDw-1:0] act,
                       input logic [OutDw-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packing model: observes accepted beats just before the active edge.
  logic [OutDw-1:0] m_data;
  logic [Ratio-1:0] m_lanes;
  int               m_cnt;
  initial begin
    m_data = '0; m_lanes = '0; m_cnt = 0;
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        m_data = '0; m_lanes = '0; m_cnt = 0;
        exp_q.delete();
      end else if (bus.valid_i && bus.ready_o) begin
        m_data[m_cnt*InDw +: InDw] = bus.data_i;
        m_lanes[m_cnt] = 1'b1;
        if (m_cnt == int'(Ratio) - 1 || bus.last_i) begin
          exp_q.push_back('{data: m_data, lanes: m_lanes, last: bus.last_i});
          m_data = '0; m_lanes = '0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Monitor: pops on every output handshake and checks hold under backpressure.
  logic             hold_pend = 1'b0;
  logic [OutDw-1:0] hold_data;
  logic [Ratio-1:0] hold_lanes;
  logic             hold_last;
  initial begin
    word_t w;
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", OutDw'(bus.valid_o), OutDw'(1'b1));
          check("hold_data", bus.data_o, hold_data);
          check("hold_lanes_last", OutDw'({bus.lanes_o, bus.last_o}),
                OutDw'({hold_lanes, hold_last}));
        end
        if (bus.valid_o && bus.ready_i) begin
          n_words++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_unexpected: got word %0h expected none", bus.data_o);
          end else begin
            w = exp_q.pop_front();
            check("sb_data", bus.data_o, w.data);
            check("sb_lanes", OutDw'(bus.lanes_o), OutDw'(w.lanes));
            check("sb_last", OutDw'(bus.last_o), OutDw'(w.last));
          end
        end
        hold_pend  = bus.valid_o && !bus.ready_i;
        hold_data  = bus.data_o;
        hold_lanes = bus.lanes_o;
        hold_last  = bus.last_o;
      end
    end
  end

  // Presents one beat at a negedge and returns (at negedge+4) once it will be accepted.
  task automatic send(input logic [InDw-1:0] d, input logic l, output int waits);
    waits = 0;
    @(negedge clk);
    bus.valid_i = 1'b1; bus.data_i = d; bus.last_i = l;
    #4;
    while (!bus.ready_o && waits < 200) begin
      @(negedge clk); #4;
      waits++;
    end
    if (!bus.ready_o) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: got ready_o=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.valid_i = 1'b0; bus.last_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, OutDw'(bus.ready_o), '0);
    check({name, "_valid"}, OutDw'(bus.valid_o), '0);
    check({name, "_data"}, bus.data_o, '0);
    check({name, "_lanes_last"}, OutDw'({bus.lanes_o, bus.last_o}), '0);
  endtask

  initial begin
    int               w;
    int               waits_sum;
    logic [OutDw-1:0] exp_data;
    logic [OutDw-1:0] word2;
    int               sent;
    int               cyc;
    logic             pending;

    rst = 1'b1;
    bus.valid_i = 1'b0; bus.data_i = '0; bus.last_i = 1'b0; bus.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #4 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;
    #4 check("ready_after_reset", OutDw'(bus.ready_o), OutDw'(1'b1));

    // 1: full word at ratio 8, sink always ready
    waits_sum = 0;
    exp_data = '0;
    for (int k = 0; k < int'(Ratio); k++) begin
      send(InDw'(k + 1), 1'b0, w);
      waits_sum += w;
      exp_data[k*InDw +: InDw] = InDw'(k + 1);
    end
    check("t1_ready_never_low", OutDw'(waits_sum), '0);
    idle(); #4;
    check("t1_valid", OutDw'(bus.valid_o), OutDw'(1'b1));
    check("t1_data", bus.data_o, exp_data);
    check("t1_lanes", OutDw'(bus.lanes_o), OutDw'(8'hFF));
    check("t1_last", OutDw'(bus.last_o), '0);

    // 2: early termination after three beats, then next beat lands in lane 0
    send(64'hA, 1'b0, w);
    send(64'hB, 1'b0, w);
    send(64'hC, 1'b1, w);
    idle(); #4;
    exp_data = '0;
    exp_data[63:0] = 64'hA; exp_data[127:64] = 64'hB; exp_data[191:128] = 64'hC;
    check("t2_valid", OutDw'(bus.valid_o), OutDw'(1'b1));
    check("t2_data", bus.data_o, exp_data);
    check("t2_lanes", OutDw'(bus.lanes_o), OutDw'(8'h07));
    check("t2_last", OutDw'(bus.last_o), OutDw'(1'b1));
    send(64'hD, 1'b1, w);
    idle(); #4;
    check("t2_next_lane0_data", bus.data_o, OutDw'(64'hD));
    check("t2_next_lane0_lanes", OutDw'(bus.lanes_o), OutDw'(8'h01));

    // 3: sink stalled while 16 beats are offered
    @(negedge clk) bus.ready_i = 1'b0;
    exp_data = '0; word2 = '0;
    for (int k = 0; k < 16; k++) begin
      send(InDw'(32'h100 + k), 1'b0, w);
      if (k < 8) exp_data[k*InDw +: InDw] = InDw'(32'h100 + k);
      else       word2[(k-8)*InDw +: InDw] = InDw'(32'h100 + k);
    end
    idle(); #4;
    check("t3_ready_low", OutDw'(bus.ready_o), '0);
    check("t3_word1_data", bus.data_o, exp_data);
    repeat (3) begin
      @(negedge clk); #4;
      check("t3_ready_stays_low", OutDw'(bus.ready_o), '0);
    end
    @(negedge clk) bus.ready_i = 1'b1;
    @(negedge clk); #4;
    check("t3_word2_valid", OutDw'(bus.valid_o), OutDw'(1'b1));
    check("t3_word2_data", bus.data_o, word2);
    check("t3_ready_back", OutDw'(bus.ready_o), OutDw'(1'b1));

    // 4: reset mid-word discards the partial word
    for (int k = 0; k < 5; k++) send(InDw'(32'h300 + k), 1'b0, w);
    @(negedge clk);
    bus.valid_i = 1'b0; rst = 1'b1;
    @(negedge clk); #4;
    check_reset_outputs("t4_in_reset");
    @(negedge clk) rst = 1'b0;
    exp_data = '0;
    for (int k = 0; k < int'(Ratio); k++) begin
      send(InDw'(32'h400 + k), 1'b0, w);
      exp_data[k*InDw +: InDw] = InDw'(32'h400 + k);
    end
    idle(); #4;
    check("t4_fresh_data", bus.data_o, exp_data);
    check("t4_fresh_lanes", OutDw'(bus.lanes_o), OutDw'(8'hFF));

    // 6: single-beat packets back to back, one word per cycle
    for (int i = 0; i < 6; i++) begin
      send(InDw'(32'h600 + i), 1'b1, w);
      if (i > 0) begin
        check("t6_valid", OutDw'(bus.valid_o), OutDw'(1'b1));
        check("t6_data", bus.data_o, OutDw'(32'h600 + i - 1));
        check("t6_lanes_last", OutDw'({bus.lanes_o, bus.last_o}), OutDw'({8'h01, 1'b1}));
      end
    end
    idle(); #4;
    check("t6_final_data", bus.data_o, OutDw'(32'h605));

    // 5: random valid/ready with random packet ends
    sent = 0; cyc = 0; pending = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus.ready_i = 1'($urandom_range(0, 1));
      if (!pending && $urandom_range(0, 1) == 1) begin
        pending     = 1'b1;
        bus.data_i  = {$urandom, $urandom};
        bus.last_i  = ($urandom_range(0, 7) == 0);
      end
      bus.valid_i = pending;
      #4;
      if (pending && bus.ready_o) begin
        sent++;
        pending = 1'b0;
      end
    end
    check("t5_all_beats_sent", OutDw'(sent), OutDw'(1000));
    @(negedge clk) bus.ready_i = 1'b1;
    bus.valid_i = 1'b0;
    send(64'hF1F1, 1'b1, w);
    idle();
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    #4 check("final_queue_empty", OutDw'(exp_q.size()), '0);
    check("t5_idle_valid", OutDw'(bus.valid_o), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
